// File: rtl/sd_host_defs.sv
// Shared SD host definitions: CRC7 polynomial, standard frame lengths, and the
// deserializer FSM state encoding.
package sd_host_defs;

  // x^7 + x^3 + 1, with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned CMD_FRAME_W  = 48;
  localparam int unsigned R2_FRAME_W   = 136;
  localparam int unsigned R2_CRC_START = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } deser_state_e;

endpackage

// File: rtl/sd_frame_deserializer_if.sv
// Frame output port of the CMD deserializer: a frame with its status on a
// valid/ready handshake, plus the overrun pulse.
interface sd_frame_deserializer_if
  import sd_host_defs::*;
#(
  parameter int unsigned FRAME_W = CMD_FRAME_W
) ();

  logic [FRAME_W-1:0] frame_out;
  logic               frame_valid;
  logic               frame_ready;
  logic               end_err;
  logic               crc_err;
  logic               overrun;

  modport master (
    output frame_out, frame_valid, end_err, crc_err, overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_out, frame_valid, end_err, crc_err, overrun,
    output frame_ready
  );

endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1, initial value 0). clear_i wins over enable_i.
// Shared between the CMD receive and transmit paths.
module sd_crc7_serial
  import sd_host_defs::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       feedback;

  always_comb begin
    feedback = crc_q[6] ^ data_i;
    crc_d    = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (enable_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_frame_deserializer.sv
// Serial-to-parallel SD CMD frame receiver, MSB first, with end-bit and CRC7
// status. The CRC7 checker is built only when SD_DESER_CRC7_EN is defined.
module sd_frame_deserializer
  import sd_host_defs::*;
#(
  parameter int unsigned FRAME_W   = CMD_FRAME_W,
  parameter int unsigned CRC_START = 0
) (
  input  logic                    sd_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    serial_in,
  output logic                    busy,
  sd_frame_deserializer_if.master frm
);

  localparam int unsigned CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_W - 1);

  deser_state_e       state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-2:0] shift_q;
  logic [FRAME_W-1:0] frame_q;
  logic               frame_valid_q;
  logic               busy_q;
  logic               end_err_q;
  logic               crc_err_q;
  logic               overrun_q;
  logic               crc_bad;

`ifdef SD_DESER_CRC7_EN
  logic [6:0]     crc;
  logic [CNT_W:0] cnt_inc;
  logic           crc_en;

  // cnt_q is the index of the bit sampled on this edge. The start bit (index 0)
  // is a zero shifted into a cleared CRC, so skipping it in IDLE changes nothing.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign crc_en  = enable && (cnt_inc > (CNT_W + 1)'(CRC_START)) &&
                   (cnt_q <= CNT_W'(FRAME_W - 9));

  sd_crc7_serial u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear_i  (state_q == StIdle),
    .enable_i (crc_en),
    .data_i   (serial_in),
    .crc_o    (crc)
  );

  // At the end-bit edge the received CRC field sits in the low seven bits.
  assign crc_bad = (crc != shift_q[6:0]);
`else
  logic unused_crc_start;
  assign unused_crc_start = ^CRC_START;
  assign crc_bad          = 1'b0;
`endif

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      end_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frm.frame_ready && frame_valid_q) begin
        frame_valid_q <= 1'b0;
      end
      if (enable) begin
        unique case (state_q)
          StIdle: begin
            if (!serial_in) begin
              state_q <= StShift;
              shift_q <= '0;
              cnt_q   <= CNT_W'(1);
              busy_q  <= 1'b1;
            end
          end
          StShift: begin
            shift_q <= {shift_q[FRAME_W-3:0], serial_in};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LastIdx) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              // A held frame is never overwritten; the new one is dropped instead.
              if (!frame_valid_q || frm.frame_ready) begin
                frame_q       <= {shift_q, serial_in};
                end_err_q     <= !serial_in;
                crc_err_q     <= crc_bad;
                frame_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy            = busy_q;
  assign frm.frame_out   = frame_q;
  assign frm.frame_valid = frame_valid_q;
  assign frm.end_err     = end_err_q;
  assign frm.crc_err     = crc_err_q;
  assign frm.overrun     = overrun_q;

endmodule
